// File: rtl/jz_core_mem_arbiter_pkg.sv
// Shared types for the IF/MEM single-port RAM arbiter.
// Response owner encoding plus the next-owner helper used by the response FSM.
package jz_core_mem_arbiter_pkg;

    localparam int ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_IRESP = 2'b01,
        ST_DRESP = 2'b10
    } arb_state_e;

    function automatic arb_state_e arb_next_owner(input logic inst_gnt, input logic data_gnt);
        if (inst_gnt)      return ST_IRESP;
        else if (data_gnt) return ST_DRESP;
        else               return ST_IDLE;
    endfunction

endpackage

// File: rtl/jz_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; forced_o lets fetch win at LIMIT.
// Cleared whenever fetch is granted or stops requesting.
module jz_arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req_i,
    input  logic inst_gnt_i,
    output logic forced_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inst_gnt_i || !inst_req_i) begin
            cnt_d = '0;
        end else if (cnt_q != W'(LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign forced_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/jz_core_mem_arbiter.sv
// Shares the single-port RAM between fetch and load/store; data wins unless fetch is starved.
// Optional ARB_PERF_CNT_EN adds conflict/forced-win counters.
module jz_core_mem_arbiter
    import jz_core_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_rvalid_o,
    output logic [DATA_W-1:0] inst_data_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       conflict_cnt_o,
    output logic [31:0]       force_cnt_o,
`endif
    output logic              stallreq_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       store_q;
    logic       store_d;
    logic       forced;
    logic       inst_gnt;
    logic       data_gnt;

    jz_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .W     (ARB_STARVE_W)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inst_req_i (inst_req_i),
        .inst_gnt_i (inst_gnt),
        .forced_o   (forced)
    );

    // Nothing is granted while reset is held, so no access is launched into a discarded response.
    assign data_gnt   = ~rst & data_req_i & ~(forced & inst_req_i);
    assign inst_gnt   = ~rst & inst_req_i & ~data_gnt;
    assign inst_gnt_o = inst_gnt;
    assign data_gnt_o = data_gnt;
    assign stallreq_o = ~rst & ((inst_req_i & ~inst_gnt) | (data_req_i & ~data_gnt));

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_sel_o   = 4'b0000;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (data_gnt) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = data_we_i;
            mem_sel_o   = data_sel_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (inst_gnt) begin
            mem_ce_o    = 1'b1;
            mem_sel_o   = 4'b1111;
            mem_addr_o  = inst_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d = arb_next_owner(inst_gnt, data_gnt);
        store_d = data_gnt & data_we_i;
    end

    // Response data is steered straight from the RAM to whichever port owns the in-flight access.
    always_comb begin
        inst_rvalid_o = 1'b0;
        inst_data_o   = '0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        if (!rst) begin
            case (state_q)
                ST_IRESP: begin
                    inst_rvalid_o = 1'b1;
                    inst_data_o   = mem_rdata_i;
                end
                ST_DRESP: begin
                    data_rvalid_o = 1'b1;
                    data_rdata_o  = store_q ? '0 : mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;
    logic [31:0] force_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            force_cnt_q    <= '0;
        end else begin
            if (inst_req_i && data_req_i) conflict_cnt_q <= conflict_cnt_q + 32'd1;
            if (inst_gnt && forced && data_req_i) force_cnt_q <= force_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign force_cnt_o    = force_cnt_q;
`endif

endmodule

// File: tb/tb_jz_core_mem_arbiter.sv
// Directed bench for jz_core_mem_arbiter with a behavioural 1-cycle RAM.
// Build with ARB_PERF_CNT_EN defined to also check the performance counters.
module tb_jz_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_data;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        stallreq;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
    logic [31:0] force_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    jz_core_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_i    (inst_req),
        .inst_addr_i   (inst_addr),
        .inst_gnt_o    (inst_gnt),
        .inst_rvalid_o (inst_rvalid),
        .inst_data_o   (inst_data),
        .data_req_i    (data_req),
        .data_we_i     (data_we),
        .data_sel_i    (data_sel),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_rdata_o  (data_rdata),
        .mem_ce_o      (mem_ce),
        .mem_we_o      (mem_we),
        .mem_sel_o     (mem_sel),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
`ifdef ARB_PERF_CNT_EN
        .conflict_cnt_o(conflict_cnt),
        .force_cnt_o   (force_cnt),
`endif
        .stallreq_o    (stallreq)
    );

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 + i;
    end

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_sel[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and drive the request ports 2ns after the edge.
    task automatic cyc(input logic r, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dsel,
                       input logic [31:0] daddr, input logic [31:0] dwdata);
        @(posedge clk);
        #2;
        rst        = r;
        inst_req   = ireq;
        inst_addr  = iaddr;
        data_req   = dreq;
        data_we    = dwe;
        data_sel   = dsel;
        data_addr  = daddr;
        data_wdata = dwdata;
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
        data_we = 1'b0; data_sel = 4'h0; data_addr = '0; data_wdata = '0;

        // Requests during reset must be ignored.
        repeat (2) @(posedge clk);
        cyc(1, 1, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
        check("rst_inst_gnt", 32'(inst_gnt), 32'h0);
        check("rst_data_gnt", 32'(data_gnt), 32'h0);
        check("rst_mem_ce",   32'(mem_ce),   32'h0);
        check("rst_stall",    32'(stallreq), 32'h0);
        check("rst_rvalids",  {inst_rvalid, data_rvalid}, 32'h0);

        cyc(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("idle_mem_ce",  32'(mem_ce), 32'h0);
        check("idle_rvalids", {inst_rvalid, data_rvalid}, 32'h0);

        // Back-to-back fetch 0x0, 0x4, 0x8.
        cyc(0, 1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f0_gnt",   32'(inst_gnt), 32'h1);
        check("f0_ce",    32'(mem_ce),   32'h1);
        check("f0_we",    32'(mem_we),   32'h0);
        check("f0_sel",   32'(mem_sel),  32'hF);
        check("f0_stall", 32'(stallreq), 32'h0);
        cyc(0, 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f1_gnt",    32'(inst_gnt),    32'h1);
        check("f1_addr",   mem_addr,         32'h4);
        check("f0_rvalid", 32'(inst_rvalid), 32'h1);
        check("f0_data",   inst_data,        32'hC0DE_0000);
        cyc(0, 1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f1_data",   inst_data,        32'hC0DE_0001);
        check("f2_stall",  32'(stallreq),    32'h0);
        cyc(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("f2_data",   inst_data,        32'hC0DE_0002);
        check("f2_rvalid", 32'(inst_rvalid), 32'h1);
        check("f_end_ce",  32'(mem_ce),      32'h0);

        // Simultaneous requests: load 0x100 wins, fetch 0xC stalls.
        cyc(0, 1, 32'hC, 1, 0, 4'hF, 32'h100, 32'h0);
        check("both_data_gnt", 32'(data_gnt), 32'h1);
        check("both_inst_gnt", 32'(inst_gnt), 32'h0);
        check("both_stall",    32'(stallreq), 32'h1);
        check("both_addr",     mem_addr,      32'h100);
        cyc(0, 1, 32'hC, 0, 0, 4'h0, 32'h0, 32'h0);
        check("ld_rvalid",     32'(data_rvalid), 32'h1);
        check("ld_rdata",      data_rdata,       32'hC0DE_0040);
        check("ld_inst_rv",    32'(inst_rvalid), 32'h0);
        check("ld_inst_data",  inst_data,        32'h0);
        check("fC_gnt",        32'(inst_gnt),    32'h1);
        cyc(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("fC_data",       inst_data,        32'hC0DE_0003);
        check("fC_data_rv",    32'(data_rvalid), 32'h0);

        // Partial store, then read back the merged word.
        cyc(0, 0, 32'h0, 1, 1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        check("st_gnt",   32'(data_gnt), 32'h1);
        check("st_we",    32'(mem_we),   32'h1);
        check("st_sel",   32'(mem_sel),  32'h3);
        check("st_wdata", mem_wdata,     32'hDEAD_BEEF);
        check("st_addr",  mem_addr,      32'h20);
        cyc(0, 0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0);
        check("st_ack",   32'(data_rvalid), 32'h1);
        check("st_rdata", data_rdata,       32'h0);
        cyc(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("rb_rdata", data_rdata,       32'hC0DE_BEEF);

        // Reset the cycle after a fetch grant discards the response.
        cyc(0, 1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("pre_rst_gnt", 32'(inst_gnt), 32'h1);
        cyc(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("rst_drop_rv", 32'(inst_rvalid), 32'h0);
        cyc(0, 1, 32'h10, 1, 0, 4'hF, 32'h104, 32'h0);
        check("post_rst_rv", 32'(inst_rvalid), 32'h0);
        check("post_rst_dg", 32'(data_gnt),    32'h1);

        // Build a partial starve count, then reset with both requests held.
        cyc(0, 1, 32'h10, 1, 0, 4'hF, 32'h104, 32'h0);
        cyc(0, 1, 32'h10, 1, 0, 4'hF, 32'h104, 32'h0);
        cyc(1, 1, 32'h10, 1, 0, 4'hF, 32'h104, 32'h0);
        check("rst2_gnts",  {inst_gnt, data_gnt}, 32'h0);
        check("rst2_stall", 32'(stallreq),        32'h0);
        check("rst2_drv",   32'(data_rvalid),     32'h0);

        // Six cycles of contention: fetch is forced on the fifth.
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 1, 32'h10, 1, 0, 4'hF, 32'h104, 32'h0);
            check($sformatf("cont%0d_data_gnt", k), 32'(data_gnt), (k == 5) ? 32'h0 : 32'h1);
            check($sformatf("cont%0d_inst_gnt", k), 32'(inst_gnt), (k == 5) ? 32'h1 : 32'h0);
            check($sformatf("cont%0d_stall", k),    32'(stallreq), 32'h1);
            check($sformatf("cont%0d_addr", k),     mem_addr,      (k == 5) ? 32'h10 : 32'h104);
            if (k == 1) check("cont1_drv", 32'(data_rvalid), 32'h0);
            if (k == 6) check("cont6_idata", inst_data, 32'hC0DE_0004);
        end
        cyc(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("cont_end_rdata", data_rdata, 32'hC0DE_0041);
`ifdef ARB_PERF_CNT_EN
        check("conflict_cnt", conflict_cnt, 32'd6);
        check("force_cnt",    force_cnt,    32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
